btb_update_queue: RTL and testbench
===================================

// Module: btb_update_queue
// PURPOSE
// - Buffers resolved control-flow mispredicts from the execute-stage branch unit and drains them into the BTB update port.
// - Drains one update per cycle, in order.
// - Sits directly upstream of btb: its btb_update_o drives btb.btb_update_i.
// - The frontend can hold off writes (drain_en_i), e.g. to keep the BRAM write port quiet on a same-row read.
// PARAMETERS
// - DEPTH     4          number of queue slots; power of two, >= 2
// - CNT_W     16         width of the saturating drop counter
// - VLEN      riscv::VLEN  virtual address width (package constant, not overridable)
// PORTS
// - clk_i          in   1      clock
// - rst_ni         in   1      asynchronous reset, active low
// - flush_i        in   1      discard all queued updates
// - debug_mode_i   in   1      core in debug mode; no new entries are accepted
// - resolve_valid_i in  1      branch unit resolved a control-flow instruction this cycle
// - resolve_pc_i   in   VLEN   PC of the resolved instruction
// - resolve_tgt_i  in   VLEN   resolved target address
// - resolve_mispredict_i in 1  prediction was wrong
// - resolve_btb_type_i in 1    instruction type is tracked by the BTB (JALR, not return)
// - drain_en_i     in   1      frontend permits a BTB write this cycle
// - btb_update_o   out  $bits(ariane_pkg::btb_update_t)  {valid, pc, target_address} to btb
// - occupancy_o    out  $clog2(DEPTH)+1  number of valid entries
// - drop_cnt_o     out  CNT_W  saturating count of updates lost because the queue was full
// BEHAVIOUR
// - Reset state:
//   - Queue empty; head/tail pointers 0.
//   - btb_update_o.valid=0, occupancy_o=0, drop_cnt_o=0.
// - Push condition: push = resolve_valid_i & resolve_mispredict_i & resolve_btb_type_i & !debug_mode_i & !flush_i.
// - No upstream ready: the branch unit never stalls.
//   - Push while full with no pop: entry dropped, drop_cnt_o += 1, saturating at all-ones.
// - Pop and output:
//   - btb_update_o.valid = !empty & drain_en_i & !flush_i.
//   - pc and target_address come from the head slot.
//   - A pop occurs whenever btb_update_o.valid=1.
// - Latency: an entry pushed in cycle N appears on btb_update_o no earlier than cycle N+1. No fall-through.
// - Simultaneous push and pop:
//   - Both take effect; occupancy unchanged.
//   - When full, the push is accepted because the pop frees the head slot this cycle.
// - Flush:
//   - All slots invalid next cycle; pointers return to 0.
//   - A push in the flush cycle is discarded.
//   - drop_cnt_o is NOT cleared.
// - Pointers: log2(DEPTH) bits wrapping modulo DEPTH, plus a separate occupancy counter (0..DEPTH).
//   - full = (occupancy==DEPTH); empty = (occupancy==0).
// - Debug mode: pushes are suppressed; queued entries still drain.
//   - The btb itself also gates on debug_mode_i.
// - Reset mid-operation: asynchronous. Contents are lost, and btb_update_o.valid drops to 0 immediately.
// CONFIGURATION
// - BTB_UQ_COALESCE_EN defined:
//   - Every push compares resolve_pc_i against all valid slots.
//   - Match: the target_address of the matching slot is overwritten in place. No new slot; occupancy unchanged; no drop even when full.
//   - A match on the head slot being popped in the same cycle does not coalesce; it is a normal push.
// - BTB_UQ_COALESCE_EN undefined: no comparison; duplicate PCs take separate slots, drained in order.
// STRUCTURE
// - ariane_pkg additions:
//   - btb_uq_entry_t {logic [VLEN-1:0] pc; logic [VLEN-1:0] target_address;}
//   - constant BTB_UQ_DEPTH=4.
// - Output type is the existing ariane_pkg::btb_update_t.
// - One sub-module, btb_uq_match:
//   - Combinational DEPTH-way PC comparator returning a one-hot hit vector and its index.
//   - Instantiated only under BTB_UQ_COALESCE_EN.
// - Storage: flop array of btb_uq_entry_t [DEPTH], plus valid bits.
// TESTING
// - Single push: pc=0x8000_0010, tgt=0x8000_0200, drain_en_i=1
//   -> cycle+1: valid=1 with those values; cycle+2: valid=0, occupancy 0.
// - Fill with drain_en_i=0: 5 pushes into DEPTH=4
//   -> occupancy_o=4, drop_cnt_o=1; enable drain -> the 4 entries exit in push order over 4 cycles.
// - Full, push and pop in the same cycle
//   -> push accepted, occupancy stays 4, drop_cnt_o unchanged.
// - Flush with 3 entries plus a push in the same cycle
//   -> next cycle occupancy 0 and valid=0; drop_cnt_o keeps its value.
// - Filtering: mispredict=0, or btb_type=0, or debug_mode_i=1
//   -> no enqueue; occupancy stays 0.
// - Coalescing (macro on): push pc=0x100 tgt=0x400, then pc=0x100 tgt=0x500 with drain off
//   -> occupancy 1, drained tgt=0x500.
// - Same sequence with macro off -> occupancy 2, targets 0x400 then 0x500.

Source files
------------

// File: rtl/btb_update_queue_pkg.sv
// Shared types and constants for the BTB update queue.
// In the full core these live in riscv/ariane_pkg; they are gathered here so
// the queue, its comparator and the bench build on their own.
package btb_update_queue_pkg;

  localparam int unsigned VLEN         = 64;
  localparam int unsigned BTB_UQ_DEPTH = 4;

  typedef struct packed {
    logic            valid;
    logic [VLEN-1:0] pc;
    logic [VLEN-1:0] target_address;
  } btb_update_t;

  typedef struct packed {
    logic [VLEN-1:0] pc;
    logic [VLEN-1:0] target_address;
  } btb_uq_entry_t;

endpackage

// File: rtl/btb_uq_match.sv
// DEPTH-way PC comparator for the BTB update queue.
// Returns a one-hot hit vector over the enabled slots and the index of the hit.
// Slots hold unique PCs while coalescing is active, so at most one bit is set.
module btb_uq_match
  import btb_update_queue_pkg::*;
#(
  parameter int unsigned DEPTH = BTB_UQ_DEPTH
) (
  input  logic [DEPTH-1:0]         en_i,
  input  logic [VLEN-1:0]          pc_i [DEPTH],
  input  logic [VLEN-1:0]          key_i,
  output logic [DEPTH-1:0]         hit_o,
  output logic [$clog2(DEPTH)-1:0] idx_o
);

  localparam int unsigned IW = $clog2(DEPTH);

  // Compare the key against every enabled slot and encode the hit position.
  always_comb begin
    hit_o = '0;
    idx_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (en_i[i] && (pc_i[i] == key_i)) begin
        hit_o[i] = 1'b1;
        idx_o    = IW'(i);
      end
    end
  end

endmodule

// File: rtl/btb_update_queue.sv
// BTB update queue: buffers mispredicted JALR resolutions from the branch unit
// and drains them in order, one per cycle, into the BTB update port.
// Optional feature macro: BTB_UQ_COALESCE_EN -- a push whose PC already sits
// in a queued slot rewrites that slot's target instead of taking a new slot.
module btb_update_queue
  import btb_update_queue_pkg::*;
#(
  parameter int unsigned DEPTH = BTB_UQ_DEPTH,
  parameter int unsigned CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   debug_mode_i,
  input  logic                   resolve_valid_i,
  input  logic [VLEN-1:0]        resolve_pc_i,
  input  logic [VLEN-1:0]        resolve_tgt_i,
  input  logic                   resolve_mispredict_i,
  input  logic                   resolve_btb_type_i,
  input  logic                   drain_en_i,
  output btb_update_t            btb_update_o,
  output logic [$clog2(DEPTH):0] occupancy_o,
  output logic [CNT_W-1:0]       drop_cnt_o
);

  localparam int unsigned PW       = $clog2(DEPTH);
  localparam logic [PW:0] OCC_FULL = (PW+1)'(DEPTH);

  btb_uq_entry_t    mem_q [DEPTH];
  logic [PW-1:0]    head_q, tail_q;
  logic [PW:0]      occ_q;
  logic [CNT_W-1:0] drop_q;

  logic push, pop, full, empty, coalesce, accept, drop;

  assign full  = (occ_q == OCC_FULL);
  assign empty = (occ_q == '0);
  assign push  = resolve_valid_i & resolve_mispredict_i & resolve_btb_type_i
               & ~debug_mode_i & ~flush_i;
  assign pop   = ~empty & drain_en_i & ~flush_i;

  // A full queue still takes a push when the head leaves in the same cycle.
  assign accept = push & ~coalesce & (~full | pop);
  assign drop   = push & ~coalesce & full & ~pop;

`ifdef BTB_UQ_COALESCE_EN
  logic [DEPTH-1:0] valid_q, head_mask, hit;
  logic [PW-1:0]    hit_idx;
  logic [VLEN-1:0]  slot_pc [DEPTH];

  // The head slot leaving this cycle is excluded, so a match there becomes a normal push.
  always_comb begin
    head_mask = '0;
    if (pop) head_mask[head_q] = 1'b1;
    for (int i = 0; i < DEPTH; i++) slot_pc[i] = mem_q[i].pc;
  end

  btb_uq_match #(.DEPTH(DEPTH)) u_match (
    .en_i  (valid_q & ~head_mask),
    .pc_i  (slot_pc),
    .key_i (resolve_pc_i),
    .hit_o (hit),
    .idx_o (hit_idx)
  );

  assign coalesce = push & (|hit);

  // Per-slot valid bits; set after clear so a full push+pop on the same slot stays valid.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
    end else begin
      if (pop)    valid_q[head_q] <= 1'b0;
      if (accept) valid_q[tail_q] <= 1'b1;
    end
  end
`else
  assign coalesce = 1'b0;
`endif

  // Slot storage: write the tail on accept, or rewrite a matching target on coalesce.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (accept) begin
      mem_q[tail_q] <= '{pc: resolve_pc_i, target_address: resolve_tgt_i};
    end
`ifdef BTB_UQ_COALESCE_EN
    else if (coalesce) begin
      mem_q[hit_idx].target_address <= resolve_tgt_i;
    end
`endif
  end

  // Head/tail pointers and occupancy; flush returns everything to the reset point.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else if (flush_i) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      if (pop)    head_q <= head_q + PW'(1);
      if (accept) tail_q <= tail_q + PW'(1);
      case ({accept, pop})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  // Saturating count of pushes lost to a full queue; survives flush.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      drop_q <= '0;
    end else if (drop && (drop_q != '1)) begin
      drop_q <= drop_q + 1'b1;
    end
  end

  // Head slot is presented directly; valid follows the pop qualifier.
  always_comb begin
    btb_update_o.valid          = pop;
    btb_update_o.pc             = mem_q[head_q].pc;
    btb_update_o.target_address = mem_q[head_q].target_address;
  end

  assign occupancy_o = occ_q;
  assign drop_cnt_o  = drop_q;

endmodule

// File: tb/tb_btb_update_queue.sv
// Bench for btb_update_queue: directed table, hand sequences, then random
// traffic against a queue-based reference model. Follows BTB_UQ_COALESCE_EN.
module tb_btb_update_queue;
  import btb_update_queue_pkg::*;

  localparam int unsigned DEPTH    = 4;
  localparam int unsigned CNT_W    = 4;
  localparam int          DROP_MAX = (1 << CNT_W) - 1;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            flush, dbg, rv, mis, bt, drn;
  logic [VLEN-1:0] pc, tgt;
  btb_update_t     upd;
  logic [2:0]      occ;
  logic [CNT_W-1:0] dropc;

  int vectors = 0;
  int miscompares = 0;

  btb_update_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i                (clk_i),
    .rst_ni               (rst_ni),
    .flush_i              (flush),
    .debug_mode_i         (dbg),
    .resolve_valid_i      (rv),
    .resolve_pc_i         (pc),
    .resolve_tgt_i        (tgt),
    .resolve_mispredict_i (mis),
    .resolve_btb_type_i   (bt),
    .drain_en_i           (drn),
    .btb_update_o         (upd),
    .occupancy_o          (occ),
    .drop_cnt_o           (dropc)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [63:0] pc;
    logic [63:0] tgt;
  } ment_t;
  ment_t mq[$];
  int    m_drop = 0;

  typedef struct {
    logic        rv, mis, bt, dbg, drn, fl;
    logic [63:0] pc, tgt;
    logic        ev;
    logic [63:0] epc, etgt;
    int          eocc, edrop;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic rv_, logic mis_, logic bt_, logic dbg_, logic drn_, logic fl_,
                              logic [63:0] pc_, logic [63:0] tgt_, logic ev_,
                              logic [63:0] epc_, logic [63:0] etgt_, int eocc_, int edrop_);
    vec_t v;
    v.rv = rv_; v.mis = mis_; v.bt = bt_; v.dbg = dbg_; v.drn = drn_; v.fl = fl_;
    v.pc = pc_; v.tgt = tgt_; v.ev = ev_; v.epc = epc_; v.etgt = etgt_;
    v.eocc = eocc_; v.edrop = edrop_;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge and let them settle.
  task automatic apply(input logic rv_, input logic mis_, input logic bt_, input logic dbg_,
                       input logic drn_, input logic fl_, input logic [63:0] pc_, input logic [63:0] tgt_);
    @(negedge clk_i);
    rv = rv_; mis = mis_; bt = bt_; dbg = dbg_; drn = drn_; flush = fl_; pc = pc_; tgt = tgt_;
    #1;
    vectors++;
  endtask

  // Reference behaviour at the coming rising edge, then wait for it.
  task automatic model_edge();
    bit p, pp;
    int hit;
    p  = rv & mis & bt & !dbg & !flush;
    pp = (mq.size() > 0) && drn && !flush;
    if (flush) begin
      mq.delete();
    end else begin
      if (pp) void'(mq.pop_front());
      if (p) begin
        hit = -1;
`ifdef BTB_UQ_COALESCE_EN
        foreach (mq[k]) if (mq[k].pc == pc) hit = k;
`endif
        if (hit >= 0) mq[hit].tgt = tgt;
        else if (mq.size() < DEPTH) mq.push_back('{pc, tgt});
        else if (m_drop < DROP_MAX) m_drop++;
      end
    end
    @(posedge clk_i);
  endtask

  task automatic model_check(input string tag);
    bit ev;
    ev = (mq.size() > 0) && drn && !flush;
    chk({tag, ".valid"}, 64'(upd.valid), 64'(ev));
    if (ev) begin
      chk({tag, ".pc"},  upd.pc, mq[0].pc);
      chk({tag, ".tgt"}, upd.target_address, mq[0].tgt);
    end
    chk({tag, ".occ"},  64'(occ),   64'(mq.size()));
    chk({tag, ".drop"}, 64'(dropc), 64'(m_drop));
  endtask

  task automatic push_cyc(input logic [63:0] p_, input logic [63:0] t_, input logic d_);
    apply(1, 1, 1, 0, d_, 0, p_, t_);
  endtask

  task automatic idle_cyc(input logic d_);
    apply(0, 0, 0, 0, d_, 0, 64'h0, 64'h0);
  endtask

  initial begin
    rst_ni = 1'b0;
    {flush, dbg, rv, mis, bt, drn} = '0;
    pc = '0; tgt = '0;
    #3;
    vectors++;
    chk("rst.valid", 64'(upd.valid), 64'h0);
    chk("rst.occ",   64'(occ),       64'h0);
    chk("rst.drop",  64'(dropc),     64'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    //               rv mis bt dbg drn fl  pc             tgt            ev  epc            etgt           occ drop
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 64'h0,         64'h0,         0, 64'h0,         64'h0,         0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 1, 0, 64'h8000_0010, 64'h8000_0200, 0, 64'h0,         64'h0,         0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 64'h0,         64'h0,         1, 64'h8000_0010, 64'h8000_0200, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 64'h0,         64'h0,         0, 64'h0,         64'h0,         0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 64'h1000,      64'h2000,      0, 64'h0,         64'h0,         0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 64'h1004,      64'h2004,      0, 64'h0,         64'h0,         1, 0));
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 64'h1008,      64'h2008,      0, 64'h0,         64'h0,         2, 0));
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 64'h100c,      64'h200c,      0, 64'h0,         64'h0,         3, 0));
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 64'h1010,      64'h2010,      0, 64'h0,         64'h0,         4, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 64'h0,         64'h0,         0, 64'h0,         64'h0,         4, 1));
    tbl.push_back(mk(1, 1, 1, 0, 1, 0, 64'h1014,      64'h2014,      1, 64'h1000,      64'h2000,      4, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 64'h0,         64'h0,         1, 64'h1004,      64'h2004,      4, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 64'h0,         64'h0,         1, 64'h1008,      64'h2008,      3, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 64'h0,         64'h0,         1, 64'h100c,      64'h200c,      2, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 64'h0,         64'h0,         1, 64'h1014,      64'h2014,      1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 64'h0,         64'h0,         0, 64'h0,         64'h0,         0, 1));
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 64'h3000,      64'h3100,      0, 64'h0,         64'h0,         0, 1));
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 64'h3004,      64'h3104,      0, 64'h0,         64'h0,         1, 1));
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 64'h3008,      64'h3108,      0, 64'h0,         64'h0,         2, 1));
    tbl.push_back(mk(1, 1, 1, 0, 1, 1, 64'h300c,      64'h310c,      0, 64'h0,         64'h0,         3, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 64'h0,         64'h0,         0, 64'h0,         64'h0,         0, 1));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 64'h3800,      64'h3900,      0, 64'h0,         64'h0,         0, 1));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 64'h3804,      64'h3904,      0, 64'h0,         64'h0,         0, 1));
    tbl.push_back(mk(1, 1, 1, 1, 0, 0, 64'h3808,      64'h3908,      0, 64'h0,         64'h0,         0, 1));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 64'h380c,      64'h390c,      0, 64'h0,         64'h0,         0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 64'h0,         64'h0,         0, 64'h0,         64'h0,         0, 1));
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 64'h4000,      64'h4100,      0, 64'h0,         64'h0,         0, 1));
    tbl.push_back(mk(1, 1, 1, 1, 1, 0, 64'h4004,      64'h4104,      1, 64'h4000,      64'h4100,      1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 64'h0,         64'h0,         0, 64'h0,         64'h0,         0, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].rv, tbl[i].mis, tbl[i].bt, tbl[i].dbg, tbl[i].drn, tbl[i].fl, tbl[i].pc, tbl[i].tgt);
      chk($sformatf("tbl%0d.valid", i), 64'(upd.valid), 64'(tbl[i].ev));
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d.pc", i),  upd.pc,             tbl[i].epc);
        chk($sformatf("tbl%0d.tgt", i), upd.target_address, tbl[i].etgt);
      end
      chk($sformatf("tbl%0d.occ", i),  64'(occ),   64'(tbl[i].eocc));
      chk($sformatf("tbl%0d.drop", i), 64'(dropc), 64'(tbl[i].edrop));
      model_edge();
    end

    // Duplicate PC with drain held off.
    push_cyc(64'h100, 64'h400, 0); model_edge();
    push_cyc(64'h100, 64'h500, 0); model_edge();
    idle_cyc(0);
`ifdef BTB_UQ_COALESCE_EN
    chk("coal.occ", 64'(occ), 64'd1);
`else
    chk("coal.occ", 64'(occ), 64'd2);
`endif
    model_edge();
    idle_cyc(1);
    chk("coal.v0", 64'(upd.valid), 64'h1);
    chk("coal.pc0", upd.pc, 64'h100);
`ifdef BTB_UQ_COALESCE_EN
    chk("coal.tgt0", upd.target_address, 64'h500);
    model_edge();
    idle_cyc(1);
    chk("coal.v1", 64'(upd.valid), 64'h0);
`else
    chk("coal.tgt0", upd.target_address, 64'h400);
    model_edge();
    idle_cyc(1);
    chk("coal.v1", 64'(upd.valid), 64'h1);
    chk("coal.tgt1", upd.target_address, 64'h500);
`endif
    model_edge();
    idle_cyc(1);
    chk("coal.empty", 64'(occ), 64'h0);
    model_edge();

    // Drop counter saturation: 4 accepted, 20 more dropped, counter pinned at all-ones.
    for (int i = 0; i < 24; i++) begin
      push_cyc(64'h5000 + 64'(4 * i), 64'h6000 + 64'(i), 0);
      model_edge();
    end
    idle_cyc(0);
    chk("sat.drop", 64'(dropc), 64'(DROP_MAX));
    chk("sat.occ",  64'(occ),   64'd4);
    model_edge();

    // Asynchronous reset while the queue is draining.
    idle_cyc(1);
    chk("arst.pre", 64'(upd.valid), 64'h1);
    rst_ni = 1'b0;
    #1;
    vectors++;
    chk("arst.valid", 64'(upd.valid), 64'h0);
    chk("arst.occ",   64'(occ),       64'h0);
    chk("arst.drop",  64'(dropc),     64'h0);
    mq.delete();
    m_drop = 0;
    @(negedge clk_i);
    rst_ni = 1'b1;

    for (int i = 0; i < 600; i++) begin
      apply($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 8,
            $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 5, $urandom_range(0, 29) == 0,
            64'h100 + 64'(4 * $urandom_range(0, 5)), {32'h0, $urandom});
      model_check($sformatf("rnd%0d", i));
      model_edge();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
